// File: rtl/coin_accumulator.sv
// -----------------------------------------------------------------------------
// coin_accumulator
//
// Credit front end of the vending machine. It sums coin pulses into a 4-bit
// credit and arbitrates cancel, product selection and the inactivity timeout.
// It drives the downstream change/balance stage with total, vendA and vendB.
// It also rejects coins that cannot be taken and refunds unspent credit.
//
// Parameters
//   COSTO_A      price of product A, in credit units
//   COSTO_B      price of product B, in credit units
//   MAX_TOTAL    highest credit held (<= 15)
//   TIMEOUT_CYC  idle CREDIT cycles before auto-refund (1..65535)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   coin1        in   1-cycle pulse, 1-unit coin inserted
//   coin2        in   1-cycle pulse, 2-unit coin inserted
//   sel_a        in   1-cycle pulse, product A requested
//   sel_b        in   1-cycle pulse, product B requested
//   cancel       in   1-cycle pulse, refund request
//   total        out  current credit, registered
//   vendA        out  1-cycle vend strobe for product A, registered
//   vendB        out  1-cycle vend strobe for product B, registered
//   refund       out  refunded amount, valid while refund_vld is high, else 0
//   refund_vld   out  1-cycle refund strobe
//   coin_reject  out  1-cycle pulse: the previous cycle's coin(s) were returned
//   no_credit    out  1-cycle pulse: a selection was refused for low credit
//   busy         out  high in VEND, REFUND and CLEAR
// -----------------------------------------------------------------------------
module coin_accumulator #(
  parameter int unsigned COSTO_A     = 2,
  parameter int unsigned COSTO_B     = 3,
  parameter int unsigned MAX_TOTAL   = 15,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin1,
  input  logic       coin2,
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic       cancel,
  output logic [3:0] total,
  output logic       vendA,
  output logic       vendB,
  output logic [3:0] refund,
  output logic       refund_vld,
  output logic       coin_reject,
  output logic       no_credit,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,  // total == 0, waiting for the first coin
    CREDIT = 3'd1,  // total > 0, accepting coins and selections
    VEND   = 3'd2,  // vend strobe cycle, total held for the downstream stage
    REFUND = 3'd3,  // refund strobe cycle
    CLEAR  = 3'd4   // total zeroed, one cycle before returning to IDLE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] idle_cnt, idle_cnt_nxt;

  logic [3:0]  total_nxt;
  logic        vend_a_nxt, vend_b_nxt;
  logic [3:0]  refund_nxt;
  logic        refund_vld_nxt;
  logic        coin_reject_nxt;
  logic        no_credit_nxt;

  // coin1 weighs 1 and coin2 weighs 2, so the pair is already the binary sum.
  logic [1:0]  add;
  logic [4:0]  sum;
  logic        coin_any;
  logic        coin_fits;
  logic        afford_a, afford_b;
  logic        take_a, take_b;
  logic [16:0] idle_cnt_inc;
  logic        timeout_hit;

  assign add          = {coin2, coin1};
  assign coin_any     = coin1 | coin2;
  // Five bits hold 15 + 3 without wrapping, so the bound check is exact.
  assign sum          = {1'b0, total} + {3'b000, add};
  assign coin_fits    = ({27'd0, sum} <= MAX_TOTAL);
  assign afford_a     = ({28'd0, total} >= COSTO_A);
  assign afford_b     = ({28'd0, total} >= COSTO_B);
  // A wins a joint request when it is affordable; B is considered only if A
  // was not taken.
  assign take_a       = sel_a & afford_a;
  assign take_b       = sel_b & afford_b & ~take_a;
  assign idle_cnt_inc = {1'b0, idle_cnt} + 17'd1;
  assign timeout_hit  = ({15'd0, idle_cnt_inc} == TIMEOUT_CYC);

  assign busy = (state == VEND) || (state == REFUND) || (state == CLEAR);

  // NOTE: every signal driven here is given a default before the case
  // statement, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt       = state;
    total_nxt       = total;
    idle_cnt_nxt    = '0;
    vend_a_nxt      = 1'b0;
    vend_b_nxt      = 1'b0;
    refund_nxt      = '0;
    refund_vld_nxt  = 1'b0;
    coin_reject_nxt = 1'b0;
    no_credit_nxt   = 1'b0;

    case (state)
      IDLE: begin
        // Selections and cancel carry no meaning without credit.
        if (coin_any) begin
          if (coin_fits) begin
            total_nxt = sum[3:0];
            state_nxt = CREDIT;
          end else begin
            coin_reject_nxt = 1'b1;
          end
        end
      end

      CREDIT: begin
        if (cancel) begin
          state_nxt       = REFUND;
          refund_nxt      = total;
          refund_vld_nxt  = 1'b1;
          coin_reject_nxt = coin_any;
        end else begin
          // A refused selection still lets a lower-priority select or coin
          // through in the same cycle.
          no_credit_nxt = (sel_a & ~afford_a) | (sel_b & ~afford_b & ~take_a);

          if (take_a || take_b) begin
            // total stays put so downstream sees it together with vendX.
            state_nxt       = VEND;
            vend_a_nxt      = take_a;
            vend_b_nxt      = take_b;
            coin_reject_nxt = coin_any;
          end else if (coin_any && coin_fits) begin
            total_nxt = sum[3:0];
          end else begin
            // An idle cycle: no coin accepted (a rejected coin also counts).
            coin_reject_nxt = coin_any;
            if (timeout_hit) begin
              state_nxt      = REFUND;
              refund_nxt     = total;
              refund_vld_nxt = 1'b1;
            end else begin
              idle_cnt_nxt = idle_cnt_inc[15:0];
            end
          end
        end
      end

      VEND, REFUND: begin
        state_nxt       = CLEAR;
        total_nxt       = '0;
        coin_reject_nxt = coin_any;
      end

      CLEAR: begin
        state_nxt       = IDLE;
        coin_reject_nxt = coin_any;
      end

      default: begin
        state_nxt = IDLE;
        total_nxt = '0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so that every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      total       <= '0;
      idle_cnt    <= '0;
      vendA       <= 1'b0;
      vendB       <= 1'b0;
      refund      <= '0;
      refund_vld  <= 1'b0;
      coin_reject <= 1'b0;
      no_credit   <= 1'b0;
    end else begin
      state       <= state_nxt;
      total       <= total_nxt;
      idle_cnt    <= idle_cnt_nxt;
      vendA       <= vend_a_nxt;
      vendB       <= vend_b_nxt;
      refund      <= refund_nxt;
      refund_vld  <= refund_vld_nxt;
      coin_reject <= coin_reject_nxt;
      no_credit   <= no_credit_nxt;
    end
  end

endmodule

// File: tb/tb_coin_accumulator.sv
// -----------------------------------------------------------------------------
// tb_coin_accumulator
//
// Bench for coin_accumulator. Directed scenario tasks check literal values.
// A randomized phase is compared cycle by cycle against a reference model.
// The model tracks credit and idle time as plain integers. It treats the
// busy period after a vend or refund as a countdown of locked cycles.
// -----------------------------------------------------------------------------
module tb_coin_accumulator;

  localparam int CA   = 2;
  localparam int CB   = 3;
  localparam int MAXT = 15;
  localparam int TO   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin1, coin2, sel_a, sel_b, cancel;
  logic [3:0] total;
  logic       vendA, vendB;
  logic [3:0] refund;
  logic       refund_vld, coin_reject, no_credit, busy;

  coin_accumulator #(
    .COSTO_A    (CA),
    .COSTO_B    (CB),
    .MAX_TOTAL  (MAXT),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin1      (coin1),
    .coin2      (coin2),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .cancel     (cancel),
    .total      (total),
    .vendA      (vendA),
    .vendB      (vendB),
    .refund     (refund),
    .refund_vld (refund_vld),
    .coin_reject(coin_reject),
    .no_credit  (no_credit),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model state.
  int m_total;
  int m_idle;
  int m_lock;   // remaining busy cycles after a vend or refund
  bit m_zero;   // credit is cleared on the first locked edge

  // Expected outputs after the most recent edge.
  int e_total, e_refund;
  bit e_va, e_vb, e_rv, e_rej, e_nc, e_busy;

  logic [13:0] act_vec;
  assign act_vec = {total, vendA, vendB, refund, refund_vld, coin_reject, no_credit, busy};

  function automatic logic [13:0] exp_vec();
    return {4'(e_total), e_va, e_vb, 4'(e_refund), e_rv, e_rej, e_nc, e_busy};
  endfunction

  task automatic model_reset();
    m_total = 0; m_idle = 0; m_lock = 0; m_zero = 0;
    e_total = 0; e_refund = 0;
    e_va = 0; e_vb = 0; e_rv = 0; e_rej = 0; e_nc = 0; e_busy = 0;
  endtask

  task automatic model_lock(input bit is_refund);
    if (is_refund) begin
      e_rv     = 1;
      e_refund = m_total;
    end
    m_lock = 2;
    m_zero = 1;
    m_idle = 0;
  endtask

  task automatic model_step(input bit c1, input bit c2, input bit sa, input bit sb, input bit cn);
    int add;
    bit coin, a_ok, b_ok;
    add  = int'(c1) + 2 * int'(c2);
    coin = c1 | c2;
    e_va = 0; e_vb = 0; e_rv = 0; e_refund = 0; e_rej = 0; e_nc = 0;
    if (m_lock > 0) begin
      e_rej = coin;
      if (m_zero) begin
        m_total = 0;
        m_zero  = 0;
      end
      m_lock--;
    end else if (m_total == 0) begin
      m_idle = 0;
      if (coin) begin
        if (add <= MAXT) m_total = add;
        else e_rej = 1;
      end
    end else if (cn) begin
      e_rej = coin;
      model_lock(1);
    end else begin
      a_ok = sa && (m_total >= CA);
      b_ok = sb && (m_total >= CB) && !a_ok;
      e_nc = (sa && m_total < CA) || (sb && !a_ok && m_total < CB);
      if (a_ok || b_ok) begin
        e_va  = a_ok;
        e_vb  = b_ok;
        e_rej = coin;
        model_lock(0);
      end else if (coin && (m_total + add <= MAXT)) begin
        m_total += add;
        m_idle  = 0;
      end else begin
        e_rej = coin;
        m_idle++;
        if (m_idle == TO) model_lock(1);
      end
    end
    e_total = m_total;
    e_busy  = (m_lock > 0);
  endtask

  // Drives one cycle of inputs from a negedge, then returns at the next negedge.
  task automatic step(input bit c1, input bit c2, input bit sa, input bit sb, input bit cn);
    coin1 = c1; coin2 = c2; sel_a = sa; sel_b = sb; cancel = cn;
    model_step(c1, c2, sa, sb, cn);
    @(posedge clk);
    @(negedge clk);
    coin1 = 0; coin2 = 0; sel_a = 0; sel_b = 0; cancel = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (act_vec !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", act_vec, 14'd0);
    end
    rst_n = 1'b1;
    model_reset();
    step(0, 0, 0, 0, 0);
    n_tests++;
    if (act_vec !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want %h", act_vec, 14'd0);
    end
  endtask

  task automatic test_basic_vend();
    do_reset();
    step(0, 1, 0, 0, 0);
    n_tests++;
    if (total !== 4'd2) begin n_fail++; $display("FAIL t1_coin2: total %0d want 2", total); end
    step(1, 0, 0, 0, 0);
    n_tests++;
    if (total !== 4'd3) begin n_fail++; $display("FAIL t1_coin1: total %0d want 3", total); end
    step(0, 0, 1, 0, 0);
    n_tests++;
    if ({vendA, vendB, total, busy} !== {1'b1, 1'b0, 4'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL t1_vend: vendA %b vendB %b total %0d busy %b want 1 0 3 1", vendA, vendB, total, busy);
    end
    // Coin during VEND is returned; the machine is in CLEAR next.
    step(1, 0, 0, 0, 0);
    n_tests++;
    if ({vendA, total, busy, coin_reject} !== {1'b0, 4'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL t1_clear: vendA %b total %0d busy %b reject %b want 0 0 1 1", vendA, total, busy, coin_reject);
    end
    // Coin during CLEAR is returned too; then back in IDLE.
    step(1, 0, 0, 0, 0);
    n_tests++;
    if ({total, busy, coin_reject} !== {4'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL t1_idle: total %0d busy %b reject %b want 0 0 1", total, busy, coin_reject);
    end
    step(1, 0, 0, 0, 0);
    n_tests++;
    if ({total, coin_reject} !== {4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL t1_next_coin: total %0d reject %b want 1 0", total, coin_reject);
    end
  endtask

  task automatic test_no_credit();
    do_reset();
    step(0, 0, 1, 1, 1);
    n_tests++;
    if ({no_credit, busy, refund_vld, total} !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL t2_idle_ignore: no_credit %b busy %b refund_vld %b total %0d want 0 0 0 0",
               no_credit, busy, refund_vld, total);
    end
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    n_tests++;
    if ({no_credit, total, busy, vendB} !== {1'b1, 4'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL t2_refused: no_credit %b total %0d busy %b vendB %b want 1 2 0 0", no_credit, total, busy, vendB);
    end
    // A refused select does not block a coin in the same cycle.
    step(1, 0, 0, 1, 0);
    n_tests++;
    if ({no_credit, total} !== {1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL t2_refused_coin: no_credit %b total %0d want 1 3", no_credit, total);
    end
    step(0, 0, 0, 1, 0);
    n_tests++;
    if ({vendA, vendB, no_credit, total} !== {1'b0, 1'b1, 1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL t2_vend_b: vendA %b vendB %b no_credit %b total %0d want 0 1 0 3", vendA, vendB, no_credit, total);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
    n_tests++;
    if (total !== 4'd14) begin n_fail++; $display("FAIL t3_fill: total %0d want 14", total); end
    step(0, 1, 0, 0, 0);
    n_tests++;
    if ({coin_reject, total} !== {1'b1, 4'd14}) begin
      n_fail++;
      $display("FAIL t3_reject2: reject %b total %0d want 1 14", coin_reject, total);
    end
    step(1, 0, 0, 0, 0);
    n_tests++;
    if ({coin_reject, total} !== {1'b0, 4'd15}) begin
      n_fail++;
      $display("FAIL t3_max: reject %b total %0d want 0 15", coin_reject, total);
    end
    step(1, 0, 0, 0, 0);
    n_tests++;
    if ({coin_reject, total} !== {1'b1, 4'd15}) begin
      n_fail++;
      $display("FAIL t3_reject1: reject %b total %0d want 1 15", coin_reject, total);
    end
    step(1, 1, 0, 0, 0);
    n_tests++;
    if ({coin_reject, total} !== {1'b1, 4'd15}) begin
      n_fail++;
      $display("FAIL t3_reject3: reject %b total %0d want 1 15", coin_reject, total);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1);
    n_tests++;
    if ({refund_vld, refund, vendA, vendB, coin_reject, total} !== {1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 4'd5}) begin
      n_fail++;
      $display("FAIL t4_cancel: vld %b refund %0d vendA %b vendB %b reject %b total %0d want 1 5 0 0 1 5",
               refund_vld, refund, vendA, vendB, coin_reject, total);
    end
    step(0, 0, 0, 0, 0);
    n_tests++;
    if ({refund_vld, refund, total, busy} !== {1'b0, 4'd0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL t4_clear: vld %b refund %0d total %0d busy %b want 0 0 0 1", refund_vld, refund, total, busy);
    end
    step(0, 0, 0, 0, 0);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL t4_idle: busy %b want 0", busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 0);
    n_tests++;
    if ({refund_vld, total} !== {1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL t5_early: vld %b total %0d want 0 3", refund_vld, total);
    end
    step(0, 0, 0, 0, 0);
    n_tests++;
    if ({refund_vld, refund} !== {1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL t5_strobe: vld %b refund %0d want 1 3", refund_vld, refund);
    end
    step(0, 0, 0, 0, 0);
    n_tests++;
    if ({refund_vld, total} !== {1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL t5_zero: vld %b total %0d want 0 0", refund_vld, total);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    do_reset();
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    n_tests++;
    if (vendA !== 1'b1) begin n_fail++; $display("FAIL t6_pre: vendA %b want 1", vendA); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({vendA, total, busy} !== {1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL t6_async: vendA %b total %0d busy %b want 0 0 0", vendA, total, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      n_tests++;
      if (act_vec !== 14'd0) begin
        n_fail++;
        $display("FAIL t6_after: got %h want %h", act_vec, 14'd0);
      end
    end
  endtask

  task automatic test_both_inputs();
    do_reset();
    step(1, 1, 0, 0, 0);
    n_tests++;
    if (total !== 4'd3) begin n_fail++; $display("FAIL t7_coins: total %0d want 3", total); end
    step(0, 0, 1, 1, 0);
    n_tests++;
    if ({vendA, vendB} !== 2'b10) begin
      n_fail++;
      $display("FAIL t7_sel: vendA %b vendB %b want 1 0", vendA, vendB);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit c1, c2, sa, sb, cn;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      c1 = ($urandom_range(0, 99) < 25);
      c2 = ($urandom_range(0, 99) < 25);
      sa = ($urandom_range(0, 99) < 10);
      sb = ($urandom_range(0, 99) < 10);
      cn = ($urandom_range(0, 99) < 4);
      step(c1, c2, sa, sb, cn);
      n_tests++;
      if (act_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand_cycle %0d: got %h want %h", i, act_vec, exp_vec());
      end
      n_tests++;
      if (vendA && vendB) begin
        n_fail++;
        $display("FAIL rand_vend_excl %0d: vendA %b vendB %b want not both", i, vendA, vendB);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    coin1 = 0; coin2 = 0; sel_a = 0; sel_b = 0; cancel = 0;
    model_reset();
    test_reset();
    test_basic_vend();
    test_no_credit();
    test_overflow();
    test_cancel();
    test_timeout();
    test_async_reset();
    test_both_inputs();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
